// File: rtl/x_mem_arb_pkg.sv
// Shared types and constants for the x_mem_arb memory arbiter.
package x_mem_arb_pkg;

  // Arbiter FSM: IDLE picks a requester, GRANT forwards it to memory.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // One memory request as presented to the memory port.
  typedef struct packed {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_req_t;

  // Default number of cycles a grant may wait for the memory accept.
  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/x_mem_arb_if.sv
// Requester-side and memory-side signals of the x_mem_arb arbiter.
// The arbiter connects through the slave modport; the masters and the
// memory model drive the i_* signals through the master modport.
interface x_mem_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]       i_req_valid;
  logic [NREQ-1:0]       i_req_rnw;
  logic [NREQ-1:0][31:0] i_req_addr;
  logic [NREQ-1:0][31:0] i_req_data;
  logic [NREQ-1:0]       o_req_accept;
  logic [31:0]           o_req_data;
  logic                  o_mem_valid;
  logic                  o_mem_rnw;
  logic [31:0]           o_mem_addr;
  logic [31:0]           o_mem_data;
  logic [31:0]           i_mem_data;
  logic                  i_mem_accept;
  logic                  o_timeout;

  modport slave (
    input  i_req_valid, i_req_rnw, i_req_addr, i_req_data,
    input  i_mem_data, i_mem_accept,
    output o_req_accept, o_req_data,
    output o_mem_valid, o_mem_rnw, o_mem_addr, o_mem_data,
    output o_timeout
  );

  modport master (
    output i_req_valid, i_req_rnw, i_req_addr, i_req_data,
    output i_mem_data, i_mem_accept,
    input  o_req_accept, o_req_data,
    input  o_mem_valid, o_mem_rnw, o_mem_addr, o_mem_data,
    input  o_timeout
  );
endinterface

// File: rtl/x_rr_pick.sv
// Combinational round-robin picker: returns the first valid requester at or
// after the pointer, wrapping from NREQ-1 back to 0.
module x_rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);
  // cand[k] is the requester index at offset k from the pointer; chain[k]
  // holds the nearest valid candidate at offset k or later.
  logic [NREQ-1:0]            hit;
  logic [NREQ-1:0][IDX_W-1:0] cand;
  logic [NREQ:0][IDX_W-1:0]   chain;

  assign chain[NREQ] = '0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_off
    logic [IDX_W:0] sum;
    // Modulo-NREQ add without a divider: one conditional subtract suffices.
    assign sum       = {1'b0, ptr_i} + (IDX_W + 1)'(gi);
    assign cand[gi]  = (sum >= (IDX_W + 1)'(NREQ)) ? IDX_W'(sum - (IDX_W + 1)'(NREQ))
                                                   : sum[IDX_W-1:0];
    assign hit[gi]   = valid_i[cand[gi]];
    assign chain[gi] = hit[gi] ? cand[gi] : chain[gi+1];
  end

  assign found_o = |hit;
  assign idx_o   = chain[0];

endmodule

// File: rtl/x_mem_arb.sv
// Round-robin arbiter sharing one single-port memory among NREQ requesters.
// Optional feature macro: X_MEM_ARB_TIMEOUT_EN -- aborts a grant that waits
// TIMEOUT cycles for the memory accept; without it a grant waits forever.
module x_mem_arb
  import x_mem_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  x_mem_arb_if.slave bus
);
  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("x_mem_arb: NREQ must be in 2..8 and TIMEOUT at least 1");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_inc;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             sel_valid;
  mem_req_t         sel_req;
  logic             expired;

  logic [NREQ-1:0]  accept;
  logic [31:0]      rdata;
  logic             mem_valid;
  mem_req_t         mem_req;
  logic             timeout;

  x_rr_pick #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .valid_i(bus.i_req_valid),
    .ptr_i  (ptr_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  // Request of the currently granted requester.
  assign sel_valid    = bus.i_req_valid[grant_q];
  assign sel_req.rnw  = bus.i_req_rnw[grant_q];
  assign sel_req.addr = bus.i_req_addr[grant_q];
  assign sel_req.data = bus.i_req_data[grant_q];

  // Pointer after the granted requester, wrapping for non-power-of-2 NREQ.
  assign grant_inc = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef X_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_q, wait_d;

  // Wait counter: held at zero while idle so each grant starts counting at 0.
  always_comb begin
    wait_d = '0;
    if (state_q == GRANT) wait_d = wait_q + 1'b1;
  end

  // Wait counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) wait_q <= '0;
    else       wait_q <= wait_d;
  end

  assign expired = (state_q == GRANT) && (wait_q == CNT_W'(TIMEOUT));
`else
  assign expired = 1'b0;
`endif

  // Next-state and outputs; everything reads as zero while reset is held so a
  // reset mid-transfer never leaks a request or an accept.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    accept    = '0;
    rdata     = '0;
    mem_valid = 1'b0;
    mem_req   = '0;
    timeout   = 1'b0;
    if (!i_rst) begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_d = pick_idx;
            state_d = GRANT;
          end
        end
        GRANT: begin
          mem_req   = sel_req;
          mem_valid = sel_valid;
          if (sel_valid && bus.i_mem_accept) begin
            accept[grant_q] = 1'b1;
            rdata           = bus.i_mem_data;
            ptr_d           = grant_inc;
            state_d         = IDLE;
          end else if (!sel_valid) begin
            // Requester withdrew: abandon without accept, keep its priority.
            state_d = IDLE;
          end else if (expired) begin
            accept[grant_q] = 1'b1;
            timeout         = 1'b1;
            mem_valid       = 1'b0;
            ptr_d           = grant_inc;
            state_d         = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, grant index and round-robin pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.o_req_accept = accept;
  assign bus.o_req_data   = rdata;
  assign bus.o_mem_valid  = mem_valid;
  assign bus.o_mem_rnw    = mem_req.rnw;
  assign bus.o_mem_addr   = mem_req.addr;
  assign bus.o_mem_data   = mem_req.data;
  assign bus.o_timeout    = timeout;

endmodule

// File: tb/tb_x_mem_arb.sv
// Bench for x_mem_arb: directed scenarios with literal expectations, then
// randomized requesters and memory, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_x_mem_arb;
  localparam int NREQ = 3;
  localparam int IW   = $clog2(NREQ);
  localparam int TMO  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  x_mem_arb_if #(.NREQ(NREQ)) bus ();

  x_mem_arb #(
    .NREQ   (NREQ),
    .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: who currently owns the memory (-1 none), the round-robin start
  // position and how long the owner has waited.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_wait  = 0;
  logic [NREQ-1:0] last_acc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of the model: work out what the arbiter must show this cycle,
  // compare, and advance the model to the next cycle.
  task automatic model_cycle();
    logic [NREQ-1:0]      vsh, rsh, e_acc;
    logic [NREQ*32-1:0]   ash, dsh;
    logic [31:0]          e_rd, e_addr, e_md;
    logic                 e_mv, e_rnw, e_to;
    bit                   found;
    int                   j, o;
    e_acc = '0; e_rd = '0; e_addr = '0; e_md = '0;
    e_mv = 1'b0; e_rnw = 1'b0; e_to = 1'b0;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_wait = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        vsh = bus.i_req_valid >> j;
        if (!found && vsh[0]) begin
          found = 1; m_owner = j; m_wait = 0;
        end
      end
    end else begin
      o = m_owner;
      vsh = bus.i_req_valid >> o;
      rsh = bus.i_req_rnw >> o;
      ash = bus.i_req_addr >> (32 * o);
      dsh = bus.i_req_data >> (32 * o);
      e_mv = vsh[0]; e_rnw = rsh[0]; e_addr = ash[31:0]; e_md = dsh[31:0];
      if (vsh[0] && bus.i_mem_accept) begin
        e_acc = NREQ'(1) << o; e_rd = bus.i_mem_data;
        m_ptr = (o + 1) % NREQ; m_owner = -1;
      end else if (!vsh[0]) begin
        m_owner = -1;
      end
`ifdef X_MEM_ARB_TIMEOUT_EN
      else if (m_wait == TMO) begin
        e_acc = NREQ'(1) << o; e_to = 1'b1; e_mv = 1'b0;
        m_ptr = (o + 1) % NREQ; m_owner = -1;
      end else begin
        m_wait++;
      end
`endif
    end
    chk("m_accept",   32'(bus.o_req_accept), 32'(e_acc));
    chk("m_req_data", bus.o_req_data, e_rd);
    chk("m_mem_valid", 32'(bus.o_mem_valid), 32'(e_mv));
    chk("m_mem_rnw",  32'(bus.o_mem_rnw), 32'(e_rnw));
    chk("m_mem_addr", bus.o_mem_addr, e_addr);
    chk("m_mem_data", bus.o_mem_data, e_md);
    chk("m_timeout",  32'(bus.o_timeout), 32'(e_to));
    last_acc = e_acc;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_cycle();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.i_req_valid  = '0;
    bus.i_req_rnw    = '0;
    bus.i_req_addr   = '0;
    bus.i_req_data   = '0;
    bus.i_mem_data   = '0;
    bus.i_mem_accept = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    look();
    chk("rst_accept", 32'(bus.o_req_accept), 32'h0);
    chk("rst_mem_valid", 32'(bus.o_mem_valid), 32'h0);

    // 1: single read, memory answers in the third grant cycle.
    step();
    rst = 1'b0;
    bus.i_req_valid[0] = 1'b1; bus.i_req_rnw[0] = 1'b1; bus.i_req_addr[0] = 32'h100;
    look(); chk("t1_idle_valid", 32'(bus.o_mem_valid), 32'h0);
    step(); look();
    chk("t1_grant_valid", 32'(bus.o_mem_valid), 32'h1);
    chk("t1_addr", bus.o_mem_addr, 32'h100);
    chk("t1_rnw", 32'(bus.o_mem_rnw), 32'h1);
    step(); look(); chk("t1_wait_acc", 32'(bus.o_req_accept), 32'h0);
    step();
    bus.i_mem_accept = 1'b1; bus.i_mem_data = 32'hCAFE0001;
    look();
    chk("t1_accept", 32'(bus.o_req_accept), 32'h1);
    chk("t1_rdata", bus.o_req_data, 32'hCAFE0001);

    // 2: req0 and req1 continuously valid, memory always ready; pointer is 1.
    step();
    bus.i_req_valid = 3'b011; bus.i_req_addr[1] = 32'h180; bus.i_req_rnw[1] = 1'b1;
    bus.i_mem_data = 32'h5A5A0000;
    look(); chk("t2_idle", 32'(bus.o_req_accept), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(); look();
      chk("t2_grant", 32'(bus.o_req_accept), (i % 2 == 0) ? 32'h2 : 32'h1);
      step();
      if (i == 3) begin
        bus.i_req_valid = '0; bus.i_mem_accept = 1'b0;
      end
      look(); chk("t2_gap", 32'(bus.o_req_accept), 32'h0);
    end

    // 3: req1 write passthrough; pointer is 1.
    step();
    bus.i_req_valid = 3'b010; bus.i_req_rnw[1] = 1'b0;
    bus.i_req_addr[1] = 32'h200; bus.i_req_data[1] = 32'h12345678;
    look();
    step(); look();
    chk("t3_valid", 32'(bus.o_mem_valid), 32'h1);
    chk("t3_rnw", 32'(bus.o_mem_rnw), 32'h0);
    chk("t3_addr", bus.o_mem_addr, 32'h200);
    chk("t3_wdata", bus.o_mem_data, 32'h12345678);
    step();
    bus.i_mem_accept = 1'b1; bus.i_mem_data = 32'h0;
    look();
    chk("t3_accept", 32'(bus.o_req_accept), 32'h2);
    chk("t3_rdata", bus.o_req_data, 32'h0);

    // 4: req0 withdraws while granted; pointer (2) must not move.
    step();
    bus.i_mem_accept = 1'b0; bus.i_req_valid = 3'b001;
    bus.i_req_rnw[0] = 1'b1; bus.i_req_addr[0] = 32'h300;
    look();
    step(); look(); chk("t4_grant", 32'(bus.o_mem_valid), 32'h1);
    step(); bus.i_req_valid = 3'b000;
    look();
    chk("t4_drop_valid", 32'(bus.o_mem_valid), 32'h0);
    chk("t4_drop_acc", 32'(bus.o_req_accept), 32'h0);
    step(); bus.i_req_valid = 3'b011;
    look();
    step(); bus.i_mem_accept = 1'b1; bus.i_mem_data = 32'h0000BEEF;
    look();
    chk("t4_regrant", 32'(bus.o_req_accept), 32'h1);
    chk("t4_addr", bus.o_mem_addr, 32'h300);

    // 5: reset while req1 is granted, then it completes after release.
    step(); bus.i_mem_accept = 1'b0; bus.i_req_valid = 3'b010;
    look();
    step(); look(); chk("t5_grant", 32'(bus.o_mem_valid), 32'h1);
    step(); rst = 1'b1;
    look();
    chk("t5_rst_valid", 32'(bus.o_mem_valid), 32'h0);
    chk("t5_rst_addr", bus.o_mem_addr, 32'h0);
    step(); rst = 1'b0;
    look(); chk("t5_after_rst", 32'(bus.o_mem_valid), 32'h0);
    step(); bus.i_mem_accept = 1'b1; bus.i_mem_data = 32'h00C0FFEE;
    look();
    chk("t5_accept", 32'(bus.o_req_accept), 32'h2);
    chk("t5_rdata", bus.o_req_data, 32'h00C0FFEE);

    // 6: memory never answers; pointer is 2 so req0 is granted first.
    step();
    bus.i_mem_accept = 1'b0; bus.i_mem_data = 32'hFFFFFFFF;
    bus.i_req_valid = 3'b011; bus.i_req_addr[0] = 32'h400; bus.i_req_addr[1] = 32'h500;
    look();
`ifdef X_MEM_ARB_TIMEOUT_EN
    for (int k = 0; k < TMO; k++) begin
      step(); look();
      chk("t6_wait_valid", 32'(bus.o_mem_valid), 32'h1);
      chk("t6_wait_to", 32'(bus.o_timeout), 32'h0);
    end
    step(); look();
    chk("t6_to_acc", 32'(bus.o_req_accept), 32'h1);
    chk("t6_to_flag", 32'(bus.o_timeout), 32'h1);
    chk("t6_to_data", bus.o_req_data, 32'h0);
    chk("t6_to_valid", 32'(bus.o_mem_valid), 32'h0);
    step(); bus.i_req_valid = 3'b010;
    look();
`else
    for (int k = 0; k < 2 * TMO; k++) begin
      step(); look();
      chk("t6_hold_valid", 32'(bus.o_mem_valid), 32'h1);
      chk("t6_hold_to", 32'(bus.o_timeout), 32'h0);
      chk("t6_hold_acc", 32'(bus.o_req_accept), 32'h0);
    end
    step(); bus.i_mem_accept = 1'b1;
    look(); chk("t6_late_acc", 32'(bus.o_req_accept), 32'h1);
    step(); bus.i_mem_accept = 1'b0; bus.i_req_valid = 3'b010;
    look();
`endif
    step(); look();
    chk("t6_next_grant", bus.o_mem_addr, 32'h500);
    step(); bus.i_mem_accept = 1'b1;
    look(); chk("t6_next_acc", 32'(bus.o_req_accept), 32'h2);
    step(); bus.i_req_valid = '0; bus.i_mem_accept = 1'b0;

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int r = 0; r < NREQ; r++) begin
        if (bus.i_req_valid[IW'(r)] && last_acc[IW'(r)]) begin
          bus.i_req_valid[IW'(r)] = ($urandom_range(1) == 1);
          bus.i_req_rnw[IW'(r)]   = $urandom_range(1) == 1;
          bus.i_req_addr[IW'(r)]  = $urandom;
          bus.i_req_data[IW'(r)]  = $urandom;
        end else if (bus.i_req_valid[IW'(r)]) begin
          if ($urandom_range(49) == 0) bus.i_req_valid[IW'(r)] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          bus.i_req_valid[IW'(r)] = 1'b1;
          bus.i_req_rnw[IW'(r)]   = $urandom_range(1) == 1;
          bus.i_req_addr[IW'(r)]  = $urandom;
          bus.i_req_data[IW'(r)]  = $urandom;
        end
      end
      bus.i_mem_accept = ($urandom_range(2) == 0);
      bus.i_mem_data   = $urandom;
      rst              = ($urandom_range(99) == 0);
    end
    step();
    rst = 1'b0;
    look();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
